operand_gen: RTL and testbench
==============================

# operand_gen

Operand-pair stimulus generator that sits directly upstream of the 3-bit adder stage and feeds it `x`/`y` pairs over a valid/ready handshake. After a start command it emits an optional directed prologue of three fixed pairs, then a programmable number of pseudo-random pairs from an internal LFSR. Each pair is held stable until the consumer accepts it. Completion is flagged so the enclosing sequence can finish the run deterministically.

## Interface
Parameters:
- `W`, 3: operand width; must be ≥ 2, and 2·W ≤ 16.
- `CNT_W`, 8: width of the random-transaction counter.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a run; sampled only in IDLE or DONE.
- `dir_en`  in  1  include the directed prologue; sampled with `start`.
- `num_txn`  in  CNT_W  number of random pairs; sampled with `start`.
- `seed`  in  16  LFSR seed; sampled with `start`.
- `ready_i`  in  1  consumer accepts the current pair.
- `valid_o`  out  1  `x_o`/`y_o` hold a valid pair.
- `x_o`  out  W  operand x.
- `y_o`  out  W  operand y.
- `last_o`  out  1  the current pair is the final pair of the run.
- `busy`  out  1  high in DIR and RAND.
- `done`  out  1  high in DONE.

## Operation
- **States:** IDLE, DIR, RAND, DONE.
- **Transfer:** a pair transfers on any edge where `valid_o & ready_i`.
- **IDLE/DONE on `start`:**
  - Capture `dir_en`, `num_txn`, and `seed`.
  - Load the LFSR with `seed`, or with 16'hACE1 if `seed == 0`.
  - Clear the directed index and the random counter.
  - Go to DIR if `dir_en`; else RAND if `num_txn != 0`; else DONE.
- **DIR:**
  - Emits pairs (2^W−3, 2^W−3), (2^W−2, 2^W−2), (2^W−1, 2^W−1). For W=3 these are 5/5, 6/6, 7/7.
  - The index advances on each transfer.
  - After the third transfer, go to RAND if `num_txn != 0`, else DONE.
- **RAND:**
  - `x_o = lfsr[W-1:0]` and `y_o = lfsr[2W-1:W]`, taken from the current LFSR state.
  - On each transfer the LFSR advances and the counter increments.
  - Go to DONE on the transfer that makes the counter equal `num_txn`.
- **LFSR:**
  - Fibonacci, left shift: `lfsr <= {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}`.
  - Advances only on a RAND transfer. It never advances during a stall or in any other state.
- **`last_o`:** high with the final pair of the run. That is the third directed pair when `num_txn == 0`, otherwise the `num_txn`-th random pair.
- **`valid_o`:** high in DIR and RAND only.
- **Stability:** `x_o`, `y_o`, and `last_o` must not change while `valid_o & ~ready_i`.
- **DONE:**
  - Holds `done` high until the next `start`.
  - A new `start` in DONE behaves exactly as in IDLE.
  - `start` in DIR or RAND is ignored.
- **Output width:** `x_o`/`y_o` are W bits. The downstream sum needs W+1 bits; this block does no arithmetic.

## Timing
- **Reset values:** state IDLE, `valid_o`=0, `x_o`=0, `y_o`=0, `last_o`=0, `busy`=0, `done`=0, LFSR=16'hACE1, counters=0. All outputs are registered.
- **Reset mid-run:** the run is abandoned. `valid_o` is low from the edge where `rst` is sampled high; no partial pair remains.
- **Start latency:** `start` sampled at edge N gives `valid_o` = 1 (or `done` = 1 for an empty run) after edge N.
- **Throughput:** with `ready_i` held high, one pair per clock and no bubbles, including the DIR→RAND boundary.
- **Completion:** after the final transfer at edge M, `valid_o` = 0 and `done` = 1 after edge M.
- **Counter limit:** `num_txn` = 2^CNT_W−1 must complete without counter wrap.

## Test plan
- **Directed prologue:** reset, then `start`, `dir_en`=1, `num_txn`=0, `ready_i`=1 → pairs 5/5, 6/6, 7/7 on consecutive cycles; `last_o` only on 7/7; `done` the next cycle.
- **Random sequence:** `seed`=16'h0001, `dir_en`=0, `num_txn`=4, `ready_i`=1 → pairs (1,0), (2,0), (4,0), (0,1); `last_o` on (0,1).
- **Backpressure:** same run as above with `ready_i`=0 for 3 cycles on the second pair → (2,0) held stable for 4 cycles; the LFSR does not advance; the sequence is otherwise unchanged.
- **Edge cases:**
  - `seed`=0 → the first pair comes from 16'hACE1: (1,4).
  - `num_txn`=0 with `dir_en`=0 → `done` after one edge and `valid_o` never rises.
- **Reset and ignored start:**
  - `rst` pulsed while the second random pair is stalled → all outputs return to their reset values the next cycle.
  - `start` pulsed during RAND → no effect on the sequence.

Source files
------------

// File: rtl/operand_gen.sv
// Operand-pair generator: directed prologue then LFSR-driven random pairs
// presented to the adder stage over a valid/ready handshake.
module operand_gen #(
    parameter int W     = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             dir_en,
    input  logic [CNT_W-1:0] num_txn,
    input  logic [15:0]      seed,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [W-1:0]     x_o,
    output logic [W-1:0]     y_o,
    output logic             last_o,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DIR  = 2'd1;
    localparam logic [1:0] RAND = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [15:0]      LFSR_INIT = 16'hACE1;
    localparam logic [W-1:0]     DIR_BASE  = W'((1 << W) - 3);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    logic [1:0]       state, state_n;
    logic [15:0]      lfsr, lfsr_n, lfsr_step;
    logic [1:0]       idx, idx_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CNT_W-1:0] num, num_n;
    logic             xfer;

    logic             valid_n, last_n;
    logic [W-1:0]     x_n, y_n;

    assign xfer      = valid_o & ready_i;
    assign lfsr_step = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

    always_comb begin
        state_n = state;
        lfsr_n  = lfsr;
        idx_n   = idx;
        cnt_n   = cnt;
        num_n   = num;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    num_n  = num_txn;
                    lfsr_n = (seed == 16'd0) ? LFSR_INIT : seed;
                    idx_n  = 2'd0;
                    cnt_n  = '0;
                    if (dir_en)
                        state_n = DIR;
                    else if (num_txn != '0)
                        state_n = RAND;
                    else
                        state_n = DONE;
                end
            end
            DIR: begin
                if (xfer) begin
                    if (idx == 2'd2)
                        state_n = (num != '0) ? RAND : DONE;
                    else
                        idx_n = idx + 2'd1;
                end
            end
            RAND: begin
                if (xfer) begin
                    lfsr_n = lfsr_step;
                    cnt_n  = cnt + ONE;
                    if (cnt + ONE == num)
                        state_n = DONE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from next-state values, so a stalled pair
    // is held naturally because none of those values move without xfer.
    always_comb begin
        valid_n = 1'b0;
        last_n  = 1'b0;
        x_n     = '0;
        y_n     = '0;
        if (state_n == DIR) begin
            valid_n = 1'b1;
            x_n     = DIR_BASE + W'(idx_n);
            y_n     = DIR_BASE + W'(idx_n);
            last_n  = (idx_n == 2'd2) && (num_n == '0);
        end else if (state_n == RAND) begin
            valid_n = 1'b1;
            x_n     = lfsr_n[W-1:0];
            y_n     = lfsr_n[2*W-1:W];
            last_n  = (cnt_n + ONE == num_n);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            lfsr    <= LFSR_INIT;
            idx     <= 2'd0;
            cnt     <= '0;
            num     <= '0;
            valid_o <= 1'b0;
            x_o     <= '0;
            y_o     <= '0;
            last_o  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            lfsr    <= lfsr_n;
            idx     <= idx_n;
            cnt     <= cnt_n;
            num     <= num_n;
            valid_o <= valid_n;
            x_o     <= x_n;
            y_o     <= y_n;
            last_o  <= last_n;
            busy    <= valid_n;
            done    <= (state_n == DONE);
        end
    end

endmodule

// File: tb/tb_operand_gen.sv
// Scoreboard bench for operand_gen: directed runs push expected pairs,
// a negedge monitor pops and compares on every transfer.
module tb_operand_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        dir_en;
    logic [7:0]  num_txn;
    logic [15:0] seed;
    logic        ready_i;
    logic        valid_o;
    logic [2:0]  x_o;
    logic [2:0]  y_o;
    logic        last_o;
    logic        busy;
    logic        done;

    int n_tests = 0;
    int n_fail  = 0;
    int n_xfer  = 0;
    int n_last  = 0;
    bit sb_on   = 1'b1;

    logic [6:0] sbq[$];

    operand_gen #(.W(3), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .dir_en(dir_en),
        .num_txn(num_txn), .seed(seed), .ready_i(ready_i),
        .valid_o(valid_o), .x_o(x_o), .y_o(y_o), .last_o(last_o),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(int x, int y, int l);
        sbq.push_back({1'(l), 3'(y), 3'(x)});
    endtask

    task automatic go(logic d, logic [7:0] n, logic [15:0] s);
        dir_en  = d;
        num_txn = n;
        seed    = s;
        start   = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
    endtask

    task automatic end_check(string nm);
        chk({nm, "_done"}, {31'd0, done}, 32'd1);
        chk({nm, "_valid"}, {31'd0, valid_o}, 32'd0);
        chk({nm, "_drain"}, sbq.size(), 0);
    endtask

    logic       held = 1'b0;
    logic [6:0] held_v;

    always @(negedge clk) begin
        logic [6:0] e;
        if (valid_o && held)
            chk("stall_stable", {25'd0, last_o, y_o, x_o}, {25'd0, held_v});
        held   = valid_o && !ready_i;
        held_v = {last_o, y_o, x_o};
        if (valid_o && ready_i) begin
            n_xfer++;
            if (last_o) n_last++;
            if (sb_on) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_pair", {25'd0, last_o, y_o, x_o}, 32'hffff_ffff);
                end else begin
                    e = sbq.pop_front();
                    chk("pair", {25'd0, last_o, y_o, x_o}, {25'd0, e});
                end
            end
        end
    end

    initial begin
        rst = 1'b1; start = 1'b0; dir_en = 1'b0;
        num_txn = 8'd0; seed = 16'd0; ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, valid_o}, 32'd0);
        chk("rst_xy", {26'd0, y_o, x_o}, 32'd0);
        chk("rst_last", {31'd0, last_o}, 32'd0);
        chk("rst_busy_done", {30'd0, busy, done}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // directed prologue only
        push(5, 5, 0); push(6, 6, 0); push(7, 7, 1);
        go(1'b1, 8'd0, 16'h0001);
        chk("dir_busy", {31'd0, busy}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        end_check("dir");

        // random sequence from seed 1
        push(1, 0, 0); push(2, 0, 0); push(4, 0, 0); push(0, 1, 1);
        go(1'b0, 8'd4, 16'h0001);
        repeat (4) @(posedge clk);
        #1;
        end_check("rand");

        // backpressure on the second pair
        push(1, 0, 0); push(2, 0, 0); push(4, 0, 0); push(0, 1, 1);
        go(1'b0, 8'd4, 16'h0001);
        @(posedge clk); #1;
        ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("bp_held_x", {29'd0, x_o}, 32'd2);
        ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        end_check("bp");

        // seed 0 falls back to ACE1
        push(1, 4, 0); push(3, 0, 0); push(7, 0, 0);
        push(7, 1, 0); push(6, 3, 0); push(4, 7, 1);
        go(1'b0, 8'd6, 16'h0000);
        repeat (6) @(posedge clk);
        #1;
        end_check("seed0");

        // empty run
        go(1'b0, 8'd0, 16'h0001);
        end_check("empty");

        // directed then random with no bubble
        push(5, 5, 0); push(6, 6, 0); push(7, 7, 0);
        push(1, 0, 0); push(2, 0, 1);
        go(1'b1, 8'd2, 16'h0001);
        repeat (5) @(posedge clk);
        #1;
        end_check("dir_rand");

        // reset while second pair is stalled
        push(1, 0, 0);
        go(1'b0, 8'd4, 16'h0001);
        @(posedge clk); #1;
        ready_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_valid", {31'd0, valid_o}, 32'd0);
        chk("mid_rst_xy", {26'd0, y_o, x_o}, 32'd0);
        chk("mid_rst_flags", {29'd0, last_o, busy, done}, 32'd0);
        rst = 1'b0;
        ready_i = 1'b1;
        chk("mid_rst_drain", sbq.size(), 0);
        @(posedge clk); #1;

        // start during RAND is ignored
        push(1, 0, 0); push(2, 0, 0); push(4, 0, 0); push(0, 1, 1);
        go(1'b0, 8'd4, 16'h0001);
        dir_en = 1'b1; num_txn = 8'd1; seed = 16'h0005; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        end_check("ign_start");

        // counter limit: 255 pairs, count only
        sb_on = 1'b0;
        n_xfer = 0;
        n_last = 0;
        go(1'b0, 8'd255, 16'h1234);
        repeat (255) @(posedge clk);
        #1;
        chk("max_done", {31'd0, done}, 32'd1);
        chk("max_xfers", n_xfer, 255);
        chk("max_lasts", n_last, 1);
        sb_on = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
